// File: rtl/systolic_input_skewer.sv
// ---------------------------------------------------------------------------
// systolic_input_skewer
//
// Front-end feeder for a systolic array. Each cycle it can take one
// activation vector, one element per array row, and it puts that vector onto
// the array's data bus as a staircase. Row r comes out r cycles later than
// row 0, so that wavefronts line up across the PE grid. A cycle with no
// accepted vector shifts a zero bubble into every row. After the last vector
// of a burst, the block drains. The done output pulses in the cycle where
// that last vector's element appears on the bottom row.
//
// Ports
//   clk         in   1                 clock, all state on rising edge
//   rst_n       in   1                 asynchronous active-low reset
//   in_valid    in   1                 in_data / in_last are valid
//   in_ready    out  1                 a vector can be accepted this cycle
//   in_data     in   DATA_WIDTH*ROWS   element r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_last     in   1                 accepted vector closes the burst
//   data        out  DATA_WIDTH*ROWS   skewed vector, same packing as in_data
//   data_valid  out  ROWS              lane r of data carries a real element
//   busy        out  1                 block is not idle
//   done        out  1                 one-cycle pulse: burst fully emitted
// ---------------------------------------------------------------------------
module systolic_input_skewer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*ROWS-1:0] in_data,
    input  logic                       in_last,
    output logic [DATA_WIDTH*ROWS-1:0] data,
    output logic [ROWS-1:0]            data_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               done_r;
    logic               done_next_s;
    logic               accept_s;

    // The DRAIN state blocks new vectors. in_ready depends only on the state register.
    assign in_ready = (state_r != ST_DRAIN);
    assign accept_s = in_valid & in_ready;
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;

    // Next state and drain counter. done is computed one cycle early so that
    // it can be registered and line up with the last element on the bottom row.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_STREAM: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = CNT_W'(ROWS - 1);
                end else if (accept_s) begin
                    state_next_s = ST_STREAM;
                    cnt_next_s   = cnt_r;
                end else begin
                    state_next_s = state_r;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
        // done shows in the DRAIN cycle whose counter reads zero.
        if ((state_next_s == ST_DRAIN) && (cnt_next_s == {CNT_W{1'b0}})) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // State, drain counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            done_r  <= done_next_s;
        end
    end

    // One shift chain per row. Row r holds r+1 stages, so its latency is r+1.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] stage_data_r  [0:r];
        logic                  stage_valid_r [0:r];

        // Shift every cycle. Without an accept, zero data with valid 0 enters the chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) begin
                    stage_data_r[k]  <= '0;
                    stage_valid_r[k] <= 1'b0;
                end
            end else begin
                stage_data_r[0]  <= accept_s ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                stage_valid_r[0] <= accept_s;
                for (int k = 1; k <= r; k++) begin
                    stage_data_r[k]  <= stage_data_r[k-1];
                    stage_valid_r[k] <= stage_valid_r[k-1];
                end
            end
        end

        assign data[r*DATA_WIDTH +: DATA_WIDTH] = stage_data_r[r];
        assign data_valid[r]                    = stage_valid_r[r];
    end

endmodule
